// File: rtl/ball_track_filter.sv
// Ball track filter: locks onto a detected object and smooths its position per frame.
// Latency: outputs and oUpdate register one cycle after the frame-end cycle.
// Backpressure: none; one sample per frame, frame ends with iEnable low are ignored.
//
// Ports:
//   iVgaClk, reset             clock (rising edge), async active-high reset
//   iVgaVRequest, iEnable      frame-active strobe, frame-end enable
//   iRedPixelHIndex/VIndex     detector row (>=480 none) / column (>=640 none)
//   oRow, oCol, oDRow, oDCol   filtered position and signed per-frame velocity
//   oLocked, oUpdate           lock indication, one-cycle refresh pulse
module ball_track_filter #(
    parameter int SHIFT       = 2,
    parameter int LOCK_FRAMES = 3,
    parameter int MISS_LIMIT  = 4,
    parameter int JUMP_MAX    = 64
) (
    input  logic        iVgaClk,
    input  logic        reset,
    input  logic        iVgaVRequest,
    input  logic        iEnable,
    input  logic [8:0]  iRedPixelHIndex,
    input  logic [9:0]  iRedPixelVIndex,
    output logic [8:0]  oRow,
    output logic [9:0]  oCol,
    output logic [10:0] oDRow,
    output logic [10:0] oDCol,
    output logic        oLocked,
    output logic        oUpdate
);
    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] COAST   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, miss_q, miss_d;
    logic        vreq_q, primed_q, armed_q;
    logic [8:0]  ref_row_q, ref_row_d, row_q, row_d;
    logic [9:0]  ref_col_q, ref_col_d, col_q, col_d;
    logic [10:0] drow_q, drow_d, dcol_q, dcol_d;
    logic        locked_d, locked_q, upd_d, upd_q;

    // primed_q blocks the first cycle after reset from looking like a rising
    // edge, so a frame already in progress at reset release is discarded.
    logic fe, rise, take;
    assign fe   = vreq_q & ~iVgaVRequest;
    assign rise = primed_q & ~vreq_q & iVgaVRequest;
    assign take = fe & armed_q & iEnable;

    logic s_valid;
    assign s_valid = (iRedPixelHIndex < 9'd480) && (iRedPixelVIndex < 10'd640);

    // Consistency check against the raw previous sample while acquiring,
    // otherwise against the filtered position.
    logic [8:0]         cmp_row;
    logic [9:0]         cmp_col;
    logic signed [11:0] jr, jc;
    logic [11:0]        jr_abs, jc_abs;
    logic               good;
    assign cmp_row = (state_q == ACQUIRE) ? ref_row_q : row_q;
    assign cmp_col = (state_q == ACQUIRE) ? ref_col_q : col_q;
    assign jr      = $signed({3'b000, iRedPixelHIndex}) - $signed({3'b000, cmp_row});
    assign jc      = $signed({2'b00, iRedPixelVIndex}) - $signed({2'b00, cmp_col});
    assign jr_abs  = jr[11] ? 12'(-jr) : 12'(jr);
    assign jc_abs  = jc[11] ? 12'(-jc) : 12'(jc);
    assign good    = s_valid && (int'(jr_abs) <= JUMP_MAX) && (int'(jc_abs) <= JUMP_MAX);

    // Exponential filter step; the arithmetic shift floors toward -inf.
    logic signed [10:0] fd_r, fd_c, st_r, st_c;
    logic signed [11:0] sum_r, sum_c;
    logic [8:0]         new_row;
    logic [9:0]         new_col;
    assign fd_r  = $signed({2'b00, iRedPixelHIndex}) - $signed({2'b00, row_q});
    assign fd_c  = $signed({1'b0, iRedPixelVIndex}) - $signed({1'b0, col_q});
    assign st_r  = fd_r >>> SHIFT;
    assign st_c  = fd_c >>> SHIFT;
    assign sum_r = $signed({3'b000, row_q}) + $signed({st_r[10], st_r});
    assign sum_c = $signed({2'b00, col_q}) + $signed({st_c[10], st_c});
    assign new_row = sum_r[11] ? 9'd0  : (sum_r > 12'sd479) ? 9'd479  : sum_r[8:0];
    assign new_col = sum_c[11] ? 10'd0 : (sum_c > 12'sd639) ? 10'd639 : sum_c[9:0];

    logic [3:0] cnt_inc, miss_inc;
    assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign miss_inc = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        ref_row_d = ref_row_q;
        ref_col_d = ref_col_q;
        row_d     = row_q;
        col_d     = col_q;
        drow_d    = drow_q;
        dcol_d    = dcol_q;
        upd_d     = 1'b0;
        if (take) begin
            upd_d = 1'b1;
            case (state_q)
                SEARCH: begin
                    if (s_valid) begin
                        state_d   = ACQUIRE;
                        cnt_d     = 4'd1;
                        ref_row_d = iRedPixelHIndex;
                        ref_col_d = iRedPixelVIndex;
                    end
                end
                ACQUIRE: begin
                    if (!s_valid) begin
                        state_d = SEARCH;
                        cnt_d   = 4'd0;
                    end else begin
                        ref_row_d = iRedPixelHIndex;
                        ref_col_d = iRedPixelVIndex;
                        if (!good) begin
                            cnt_d = 4'd1;
                        end else begin
                            cnt_d = cnt_inc;
                            if (int'(cnt_inc) >= LOCK_FRAMES) begin
                                state_d = LOCKED;
                                miss_d  = 4'd0;
                                row_d   = iRedPixelHIndex;
                                col_d   = iRedPixelVIndex;
                                drow_d  = 11'd0;
                                dcol_d  = 11'd0;
                            end
                        end
                    end
                end
                default: begin  // LOCKED and COAST
                    if (good) begin
                        state_d = LOCKED;
                        miss_d  = 4'd0;
                        row_d   = new_row;
                        col_d   = new_col;
                        drow_d  = {2'b00, new_row} - {2'b00, row_q};
                        dcol_d  = {1'b0, new_col} - {1'b0, col_q};
                    end else if (state_q == LOCKED) begin
                        state_d = COAST;
                        miss_d  = 4'd1;
                    end else begin
                        miss_d = miss_inc;
                        if (int'(miss_inc) >= MISS_LIMIT) begin
                            state_d = SEARCH;
                            drow_d  = 11'd0;
                            dcol_d  = 11'd0;
                        end
                    end
                end
            endcase
        end
    end

    assign locked_d = (state_d == LOCKED) || (state_d == COAST);

    always_ff @(posedge iVgaClk or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            cnt_q     <= 4'd0;
            miss_q    <= 4'd0;
            vreq_q    <= 1'b0;
            primed_q  <= 1'b0;
            armed_q   <= 1'b0;
            ref_row_q <= 9'd0;
            ref_col_q <= 10'd0;
            row_q     <= 9'd0;
            col_q     <= 10'd0;
            drow_q    <= 11'd0;
            dcol_q    <= 11'd0;
            locked_q  <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            vreq_q    <= iVgaVRequest;
            primed_q  <= 1'b1;
            armed_q   <= armed_q | rise;
            ref_row_q <= ref_row_d;
            ref_col_q <= ref_col_d;
            row_q     <= row_d;
            col_q     <= col_d;
            drow_q    <= drow_d;
            dcol_q    <= dcol_d;
            locked_q  <= take ? locked_d : locked_q;
            upd_q     <= upd_d;
        end
    end

    assign oRow    = row_q;
    assign oCol    = col_q;
    assign oDRow   = drow_q;
    assign oDCol   = dcol_q;
    assign oLocked = locked_q;
    assign oUpdate = upd_q;
endmodule

// File: tb/tb_ball_track_filter.sv
// Directed bench for ball_track_filter: lock, filtering, jump gating, coast/drop,
// enable gating and mid-frame reset, with hand-computed expectations.
// Drives on the falling edge and samples on the falling edge after updates.
module tb_ball_track_filter;
    logic        clk = 1'b0;
    logic        rst;
    logic        vreq, en;
    logic [8:0]  hidx;
    logic [9:0]  vidx;
    logic [8:0]  o_row;
    logic [9:0]  o_col;
    logic [10:0] o_drow, o_dcol;
    logic        o_locked, o_update;

    int checks   = 0;
    int failures = 0;
    int ups;

    ball_track_filter dut (
        .iVgaClk         (clk),
        .reset           (rst),
        .iVgaVRequest    (vreq),
        .iEnable         (en),
        .iRedPixelHIndex (hidx),
        .iRedPixelVIndex (vidx),
        .oRow            (o_row),
        .oCol            (o_col),
        .oDRow           (o_drow),
        .oDCol           (o_dcol),
        .oLocked         (o_locked),
        .oUpdate         (o_update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full frame; the sample is held through the frame-end cycle and the
    // oUpdate pulses seen afterwards are counted.
    task automatic frame(input int r, input int c, input bit e, output int n);
        hidx = r[8:0];
        vidx = c[9:0];
        en   = e;
        repeat (2) @(negedge clk);
        vreq = 1'b1;
        repeat (4) @(negedge clk);
        vreq = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_update) n++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lock_at_100_200();
        for (int i = 0; i < 3; i++) frame(100, 200, 1'b1, ups);
        chk("relock_locked", int'(o_locked), 1);
        chk("relock_row", int'(o_row), 100);
    endtask

    initial begin
        rst = 1'b1; vreq = 1'b0; en = 1'b1; hidx = '0; vidx = '0;
        repeat (3) @(negedge clk);
        chk("rst_row", int'(o_row), 0);
        chk("rst_col", int'(o_col), 0);
        chk("rst_drow", int'(o_drow), 0);
        chk("rst_dcol", int'(o_dcol), 0);
        chk("rst_locked", int'(o_locked), 0);
        chk("rst_update", int'(o_update), 0);
        rst = 1'b0;

        // Lock sequence
        frame(100, 200, 1'b1, ups);
        chk("lock_f1_upd", ups, 1);
        chk("lock_f1_locked", int'(o_locked), 0);
        frame(100, 200, 1'b1, ups);
        chk("lock_f2_upd", ups, 1);
        chk("lock_f2_locked", int'(o_locked), 0);
        frame(100, 200, 1'b1, ups);
        chk("lock_f3_upd", ups, 1);
        chk("lock_f3_locked", int'(o_locked), 1);
        chk("lock_row", int'(o_row), 100);
        chk("lock_col", int'(o_col), 200);
        chk("lock_drow", int'($signed(o_drow)), 0);
        chk("lock_dcol", int'($signed(o_dcol)), 0);

        // Filtering: d=+20/-20 -> +5/-5, then d=-4 -> -1 and d=+5 -> +1
        frame(120, 180, 1'b1, ups);
        chk("filt1_row", int'(o_row), 105);
        chk("filt1_col", int'(o_col), 195);
        chk("filt1_drow", int'($signed(o_drow)), 5);
        chk("filt1_dcol", int'($signed(o_dcol)), -5);
        frame(101, 200, 1'b1, ups);
        chk("filt2_row", int'(o_row), 104);
        chk("filt2_drow", int'($signed(o_drow)), -1);
        chk("filt2_col", int'(o_col), 196);
        chk("filt2_dcol", int'($signed(o_dcol)), 1);

        // Jump threshold edge: distance 64 accepted, 65 rejected
        pulse_reset();
        chk("rst2_locked", int'(o_locked), 0);
        chk("rst2_row", int'(o_row), 0);
        lock_at_100_200();
        frame(164, 200, 1'b1, ups);
        chk("jmax_row", int'(o_row), 116);
        chk("jmax_drow", int'($signed(o_drow)), 16);
        frame(181, 200, 1'b1, ups);
        chk("jover_locked", int'(o_locked), 1);
        chk("jover_row", int'(o_row), 116);
        chk("jover_drow", int'($signed(o_drow)), 16);
        frame(118, 200, 1'b1, ups);
        chk("jback_row", int'(o_row), 116);
        chk("jback_drow", int'($signed(o_drow)), 0);

        // Jump rejection then recovery with a sub-shift step
        pulse_reset();
        lock_at_100_200();
        frame(300, 200, 1'b1, ups);
        chk("jump_locked", int'(o_locked), 1);
        chk("jump_row", int'(o_row), 100);
        frame(102, 200, 1'b1, ups);
        chk("recov_locked", int'(o_locked), 1);
        chk("recov_row", int'(o_row), 100);

        // Disabled frames are ignored entirely; then coast three, drop on fourth
        for (int i = 0; i < 2; i++) begin
            frame(480, 0, 1'b0, ups);
            chk("dis_upd", ups, 0);
            chk("dis_locked", int'(o_locked), 1);
        end
        for (int i = 0; i < 3; i++) begin
            frame(480, 200, 1'b1, ups);
            chk("coast_upd", ups, 1);
            chk("coast_locked", int'(o_locked), 1);
            chk("coast_row", int'(o_row), 100);
        end
        frame(480, 200, 1'b1, ups);
        chk("drop_locked", int'(o_locked), 0);
        chk("drop_drow", int'($signed(o_drow)), 0);
        chk("drop_row", int'(o_row), 100);

        // Reset asserted mid-frame: partial frame gives no update
        hidx = 9'd100; vidx = 10'd200; en = 1'b1;
        @(negedge clk);
        vreq = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vreq = 1'b0;
        ups = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_update) ups++;
        end
        chk("partial_upd", ups, 0);
        frame(100, 200, 1'b1, ups);
        chk("full_upd", ups, 1);
        chk("full_locked", int'(o_locked), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
